// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory port among NUM_MASTERS requesters.
// Each access holds its strobe for WAIT_STATES+1 cycles and then gives its owner a one-cycle ack.
module mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            req,
  input  logic [NUM_MASTERS-1:0]            wr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wdata,
  output logic [NUM_MASTERS-1:0]            gnt,
  output logic [NUM_MASTERS-1:0]            ack,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  output logic                              mem_rd,
  output logic                              mem_wr,
  input  logic [DATA_WIDTH-1:0]             mem_rdata
);

  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t                  state, state_nxt;
  logic [OW-1:0]           owner, owner_nxt;
  logic [OW-1:0]           last, last_nxt;
  logic [OW-1:0]           pick;
  logic [CW-1:0]           count, count_nxt;
  logic                    wr_l, wr_l_nxt;
  logic [NUM_MASTERS-1:0]  gnt_nxt, ack_nxt;
  logic [DATA_WIDTH-1:0]   rdata_nxt, mem_wdata_nxt;
  logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
  logic                    mem_rd_nxt, mem_wr_nxt;

  logic [ADDR_WIDTH-1:0]   addr_a  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]   wdata_a [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign addr_a[g]  = addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from farthest to nearest after 'l' so the nearest requester wins.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                            input logic [OW-1:0]          l);
    logic [OW-1:0] cand;
    rr_pick = l;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = OW'((int'(l) + i) % NUM_MASTERS);
      if (r[cand]) rr_pick = cand;
    end
  endfunction

  assign pick = rr_pick(req, last);

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    last_nxt      = last;
    count_nxt     = count;
    wr_l_nxt      = wr_l;
    gnt_nxt       = gnt;
    ack_nxt       = '0;
    rdata_nxt     = rdata;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_rd_nxt    = 1'b0;
    mem_wr_nxt    = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (|req) begin
          state_nxt      = BUSY;
          owner_nxt      = pick;
          wr_l_nxt       = wr[pick];
          mem_addr_nxt   = addr_a[pick];
          mem_wdata_nxt  = wdata_a[pick];
          count_nxt      = CW'(WAIT_STATES);
          gnt_nxt[pick]  = 1'b1;
          mem_rd_nxt     = ~wr[pick];
          mem_wr_nxt     = wr[pick];
        end
      end
      BUSY: begin
        if (count != '0) begin
          count_nxt  = count - CW'(1);
          mem_rd_nxt = ~wr_l;
          mem_wr_nxt = wr_l;
        end else begin
          rdata_nxt      = mem_rdata;
          ack_nxt[owner] = 1'b1;
          last_nxt       = owner;
          state_nxt      = ACK;
        end
      end
      ACK: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Everything visible at the ports is registered; reset restarts the round-robin at master 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= OW'(NUM_MASTERS - 1);
      count     <= '0;
      wr_l      <= 1'b0;
      gnt       <= '0;
      ack       <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      last      <= last_nxt;
      count     <= count_nxt;
      wr_l      <= wr_l_nxt;
      gnt       <= gnt_nxt;
      ack       <= ack_nxt;
      rdata     <= rdata_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_rd    <= mem_rd_nxt;
      mem_wr    <= mem_wr_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a WAIT_STATES=0 and a WAIT_STATES=1 build share one stimulus stream
// and are checked every cycle against a transaction-level model indexed by wait-state count.
module tb_mem_arbiter;
  localparam int NM = 2;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic [NM-1:0] req       = '0;
  logic [NM-1:0] wr        = '0;
  logic [NM*AW-1:0] addr   = '0;
  logic [NM*DW-1:0] wdata  = '0;
  logic [DW-1:0] mem_rdata = '0;

  logic [NM-1:0] gnt_o    [2];
  logic [NM-1:0] ack_o    [2];
  logic [DW-1:0] rdata_o  [2];
  logic [AW-1:0] maddr_o  [2];
  logic [DW-1:0] mwdata_o [2];
  logic          mrd_o    [2];
  logic          mwr_o    [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_MASTERS(NM), .WAIT_STATES(0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_ws0 (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .gnt(gnt_o[0]), .ack(ack_o[0]), .rdata(rdata_o[0]), .mem_addr(maddr_o[0]),
    .mem_wdata(mwdata_o[0]), .mem_rd(mrd_o[0]), .mem_wr(mwr_o[0]), .mem_rdata(mem_rdata));

  mem_arbiter #(.NUM_MASTERS(NM), .WAIT_STATES(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_ws1 (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .gnt(gnt_o[1]), .ack(ack_o[1]), .rdata(rdata_o[1]), .mem_addr(maddr_o[1]),
    .mem_wdata(mwdata_o[1]), .mem_rd(mrd_o[1]), .mem_wr(mwr_o[1]), .mem_rdata(mem_rdata));

  // Model index k is also the wait-state count. phase 0 = free, 1..k+1 = strobing, k+2 = ack.
  int            phase   [2];
  int            m_owner [2];
  int            m_last  [2];
  logic          m_wr    [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [DW-1:0] m_rdata [2];

  function automatic int rr_next(input logic [NM-1:0] r, input int l);
    logic [NM-1:0] s;
    for (int i = 1; i <= NM; i++) begin
      s = r >> ((l + i) % NM);
      if (s[0]) return (l + i) % NM;
    end
    return -1;
  endfunction

  function automatic logic [NM-1:0] onehot(input int p);
    logic [NM-1:0] one;
    one = 1;
    return one << p;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int p);
    logic [NM*AW-1:0] s;
    s = addr >> (p * AW);
    return s[AW-1:0];
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int p);
    logic [NM*DW-1:0] s;
    s = wdata >> (p * DW);
    return s[DW-1:0];
  endfunction

  function automatic logic wr_of(input int p);
    logic [NM-1:0] s;
    s = wr >> p;
    return s[0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      phase[k]   = 0;
      m_owner[k] = 0;
      m_last[k]  = NM - 1;
      m_wr[k]    = 1'b0;
      m_addr[k]  = '0;
      m_wdata[k] = '0;
      m_rdata[k] = '0;
    end
  endtask

  task automatic model_step();
    int p;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (phase[k] == 0) begin
        p = rr_next(req, m_last[k]);
        if (p >= 0) begin
          m_owner[k] = p;
          m_wr[k]    = wr_of(p);
          m_addr[k]  = addr_of(p);
          m_wdata[k] = wdata_of(p);
          phase[k]   = 1;
        end
      end else if (phase[k] <= k + 1) begin
        if (phase[k] == k + 1) m_rdata[k] = mem_rdata;
        phase[k]++;
      end else begin
        m_last[k] = m_owner[k];
        phase[k]  = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  logic [NM-1:0] e_gnt, e_ack;
  logic          e_strobe;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      e_strobe = (phase[k] >= 1) && (phase[k] <= k + 1);
      e_gnt    = (phase[k] != 0) ? onehot(m_owner[k]) : '0;
      e_ack    = (phase[k] == k + 2) ? onehot(m_owner[k]) : '0;
      chk($sformatf("gnt_ws%0d", k), 64'(gnt_o[k]), 64'(e_gnt));
      chk($sformatf("ack_ws%0d", k), 64'(ack_o[k]), 64'(e_ack));
      chk($sformatf("mem_rd_ws%0d", k), 64'(mrd_o[k]), 64'(e_strobe && !m_wr[k]));
      chk($sformatf("mem_wr_ws%0d", k), 64'(mwr_o[k]), 64'(e_strobe && m_wr[k]));
      chk($sformatf("mem_addr_ws%0d", k), 64'(maddr_o[k]), 64'(m_addr[k]));
      chk($sformatf("mem_wdata_ws%0d", k), 64'(mwdata_o[k]), 64'(m_wdata[k]));
      chk($sformatf("rdata_ws%0d", k), 64'(rdata_o[k]), 64'(m_rdata[k]));
      chk($sformatf("gnt_onehot_ws%0d", k), 64'($onehot0(gnt_o[k])), 64'(1));
      chk($sformatf("strobe_excl_ws%0d", k), 64'(mrd_o[k] & mwr_o[k]), 64'(0));
    end
  end

  initial begin
    model_reset();
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("reset_gnt", 64'(gnt_o[k]), 64'(0));
      chk("reset_ack", 64'(ack_o[k]), 64'(0));
      chk("reset_mem_rd", 64'(mrd_o[k]), 64'(0));
      chk("reset_rdata", 64'(rdata_o[k]), 64'(0));
      chk("reset_mem_addr", 64'(maddr_o[k]), 64'(0));
    end
    rst = 1'b1;

    // Single read from master 0.
    req = 2'b01; wr = 2'b00; addr = {16'h0000, 16'h0010}; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("t1_rd_c1", 64'(mrd_o[1]), 64'(1));
    chk("t1_addr_c1", 64'(maddr_o[1]), 64'h0010);
    chk("t1_gnt_c1", 64'(gnt_o[1]), 64'(2'b01));
    chk("t1_ws0_rd_c1", 64'(mrd_o[0]), 64'(1));
    tick();
    chk("t1_rd_c2", 64'(mrd_o[1]), 64'(1));
    chk("t1_ws0_ack_c2", 64'(ack_o[0]), 64'(2'b01));
    chk("t1_ws0_rdata_c2", 64'(rdata_o[0]), 64'hDEADBEEF);
    chk("t1_ws0_rd_c2", 64'(mrd_o[0]), 64'(0));
    req = 2'b00;
    tick();
    chk("t1_ack_c3", 64'(ack_o[1]), 64'(2'b01));
    chk("t1_rdata_c3", 64'(rdata_o[1]), 64'hDEADBEEF);
    chk("t1_rd_c3", 64'(mrd_o[1]), 64'(0));
    tick();
    chk("t1_gnt_c4", 64'(gnt_o[1]), 64'(0));
    chk("t1_ack_c4", 64'(ack_o[1]), 64'(0));

    // Single write from master 1.
    req = 2'b10; wr = 2'b10; addr = {16'h0020, 16'h0000}; wdata = {32'h12345678, 32'h0};
    tick();
    chk("t2_wr_c1", 64'(mwr_o[1]), 64'(1));
    chk("t2_rd_c1", 64'(mrd_o[1]), 64'(0));
    chk("t2_addr_c1", 64'(maddr_o[1]), 64'h0020);
    chk("t2_wdata_c1", 64'(mwdata_o[1]), 64'h12345678);
    chk("t2_gnt_c1", 64'(gnt_o[1]), 64'(2'b10));
    tick();
    chk("t2_wr_c2", 64'(mwr_o[1]), 64'(1));
    req = 2'b00;
    tick();
    chk("t2_ack_c3", 64'(ack_o[1]), 64'(2'b10));
    chk("t2_wr_c3", 64'(mwr_o[1]), 64'(0));
    tick();

    // Both masters requesting continuously: grants alternate starting with master 0.
    req = 2'b11; wr = 2'b00;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 1)  chk("t3_ws1_g1", 64'(gnt_o[1]), 64'(2'b01));
      if (i == 5)  chk("t3_ws1_g2", 64'(gnt_o[1]), 64'(2'b10));
      if (i == 9)  chk("t3_ws1_g3", 64'(gnt_o[1]), 64'(2'b01));
      if (i == 13) chk("t3_ws1_g4", 64'(gnt_o[1]), 64'(2'b10));
      if (i == 1)  chk("t3_ws0_g1", 64'(gnt_o[0]), 64'(2'b01));
      if (i == 4)  chk("t3_ws0_g2", 64'(gnt_o[0]), 64'(2'b10));
      if (i == 7)  chk("t3_ws0_g3", 64'(gnt_o[0]), 64'(2'b01));
      if (i == 10) chk("t3_ws0_g4", 64'(gnt_o[0]), 64'(2'b10));
      chk("t3_ack_not_both", 64'(&ack_o[1]), 64'(0));
    end
    req = 2'b00;
    repeat (4) tick();

    // Request withdrawn in the first busy cycle still completes.
    req = 2'b01; wr = 2'b00; addr = {16'h0000, 16'h0044}; mem_rdata = 32'hA5A50001;
    tick();
    req = 2'b00;
    tick();
    chk("t4_ws0_ack", 64'(ack_o[0]), 64'(2'b01));
    tick();
    chk("t4_ack", 64'(ack_o[1]), 64'(2'b01));
    chk("t4_rdata", 64'(rdata_o[1]), 64'hA5A50001);
    repeat (3) tick();
    chk("t4_idle_gnt", 64'(gnt_o[1]), 64'(0));
    chk("t4_idle_rd", 64'(mrd_o[1]), 64'(0));

    // Asynchronous reset in the middle of a read.
    req = 2'b01; wr = 2'b00;
    tick();
    chk("t5_rd_before", 64'(mrd_o[1]), 64'(1));
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t5_rd_async", 64'(mrd_o[1]), 64'(0));
    chk("t5_gnt_async", 64'(gnt_o[1]), 64'(0));
    chk("t5_ack_async", 64'(ack_o[1]), 64'(0));
    chk("t5_ws0_rd_async", 64'(mrd_o[0]), 64'(0));
    req = 2'b11;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t5_first_gnt", 64'(gnt_o[1]), 64'(2'b01));
    chk("t5_ws0_first_gnt", 64'(gnt_o[0]), 64'(2'b01));
    req = 2'b00;
    repeat (4) tick();

    // Random stress, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      req       = NM'($urandom_range(0, 3));
      wr        = NM'($urandom_range(0, 3));
      addr      = {16'($urandom), 16'($urandom)};
      wdata     = {$urandom, $urandom};
      mem_rdata = $urandom;
      tick();
    end
    req = 2'b00;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
